// File: rtl/trng_pkg.sv
// trng_pkg: sequencer state encoding and default LFSR constants per supported width.
package trng_pkg;
  typedef enum logic [1:0] {IDLE, WARM, FILL, PRESENT} state_e;
  localparam logic [4:0] TAPS5 = 5'b10100;
  localparam logic [4:0] SEED5 = 5'b00001;
  localparam logic [7:0] TAPS8 = 8'b10111000;
  localparam logic [7:0] SEED8 = 8'b00000001;
endpackage

// File: rtl/trng_lfsr_ctrl_lfsr_core.sv
// lfsr_core: Fibonacci LFSR register with load, step and hold controls.
module lfsr_core #(
  parameter int BITS = 5,
  parameter logic [BITS-1:0] TAPS = 5'b10100,
  parameter logic [BITS-1:0] SEED = 5'b00001
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [BITS-1:0] load_val_i,
  input  logic            step_i,
  output logic [BITS-1:0] state_o,
  output logic            out_bit_o
);
  logic [BITS-1:0] state_q, state_d;
  always_comb state_d = load_i ? load_val_i : step_i ? {state_q[BITS-2:0], ^(state_q & TAPS)} : state_q;
  always_ff @(posedge clk) begin
    if (reset) state_q <= SEED;
    else state_q <= state_d;
  end
  assign state_o   = state_q;
  assign out_bit_o = state_q[BITS-1];
endmodule

// File: rtl/trng_lfsr_ctrl.sv
// trng_lfsr_ctrl: seeds and warms the LFSR, then packs its serial output into handshaked words.
module trng_lfsr_ctrl import trng_pkg::*; #(
  parameter int BITS = 5,
  parameter logic [BITS-1:0] TAPS = TAPS5,
  parameter logic [BITS-1:0] SEED = SEED5,
  parameter int WARMUP = 16,
  parameter int WORD = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            seed_load,
  input  logic [BITS-1:0] seed_in,
  input  logic            word_ready,
  output logic            word_valid,
  output logic [WORD-1:0] word,
  output logic            busy,
  output logic            seed_fault,
  output logic [BITS-1:0] lfsr_state
);
  localparam int WW = WARMUP > 0 ? $clog2(WARMUP + 1) : 1;
  localparam int BW = $clog2(WORD + 1);
  state_e state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WORD-1:0] shift_q, shift_d, word_q, word_d;
  logic fault_q, fault_d, load, step, out_bit;
  logic [BITS-1:0] load_val;
  lfsr_core #(.BITS(BITS), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk(clk), .reset(reset), .load_i(load), .load_val_i(load_val),
    .step_i(step), .state_o(lfsr_state), .out_bit_o(out_bit)
  );
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    word_d   = word_q;
    fault_d  = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    load_val = seed_in == '0 ? SEED : seed_in;
    case (state_q)
      IDLE: begin
        load    = seed_load;
        fault_d = seed_load && seed_in == '0;
        if (enable) begin
          state_d = WARMUP > 0 ? WARM : FILL;
          warm_d  = '0;
          bit_d   = '0;
        end
      end
      WARM: begin
        if (!enable) state_d = IDLE;
        else begin
          step   = 1'b1;
          warm_d = warm_q + 1'b1;
          if (warm_q == WW'(WARMUP - 1)) begin
            state_d = FILL;
            bit_d   = '0;
          end
        end
      end
      FILL: begin
        if (!enable) state_d = IDLE;
        else begin
          step    = 1'b1;
          shift_d = WORD'({shift_q, out_bit});
          bit_d   = bit_q + 1'b1;
          if (bit_q == BW'(WORD - 1)) begin
            state_d = PRESENT;
            word_d  = WORD'({shift_q, out_bit});
          end
        end
      end
      PRESENT: begin
        bit_d = '0;
        if (word_ready) state_d = enable ? FILL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      warm_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      fault_q <= fault_d;
    end
  end
  assign word_valid = state_q == PRESENT;
  assign busy       = state_q != IDLE;
  assign word       = word_q;
  assign seed_fault = fault_q;
endmodule
